// File: rtl/i2c_slave.sv
// I2C target for the camera-side register bus.
// Frames: device byte, 16-bit register pointer (high then low), then data
// bytes. Writes become one-cycle wr_en strobes with an auto-incrementing
// pointer; reads fetch from the local register file via rd_req/rd_data.
// SDA is open-drain: the block only ever drives 0 or releases the line.

// Two-flop synchronizer followed by a glitch filter. The filtered output
// follows the synchronized input only after FILT consecutive differing samples.
module i2c_slave_filt #(
  parameter int FILT = 3
) (
  input  logic clk,
  input  logic rstn,
  input  logic din,
  output logic dout
);
  localparam int CW = (FILT > 1) ? $clog2(FILT) : 1;

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // Synchronize, then count consecutive samples that disagree with the output.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync <= 2'b11;
      cnt  <= '0;
      dout <= 1'b1;
    end else begin
      sync <= {sync[0], din};
      if (sync[1] == dout) begin
        cnt <= '0;
      end else if (cnt == CW'(FILT - 1)) begin
        dout <= sync[1];
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module i2c_slave #(
  parameter logic [6:0] DEV_ADDR = 7'h3C,
  parameter int         FILT     = 3
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i2c_sclk,
  inout  wire         i2c_sdat,
  output logic        wr_en,
  output logic [15:0] reg_addr,
  output logic [7:0]  wr_data,
  output logic        rd_req,
  input  logic [7:0]  rd_data,
  output logic        busy,
  output logic        err
);
  typedef enum logic [3:0] {
    S_IDLE, S_DEV, S_DEV_ACK, S_AH, S_ACK_H, S_AL, S_ACK_L,
    S_WD, S_ACK_W, S_RD, S_RACK, S_WAIT_STOP
  } state_t;

  // Line 1 is SCL, line 0 is SDA.
  logic [1:0] pin, filt, filt_d;
  logic       scl_rise, scl_fall, start_det, stop_det;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;   // completed bits of the current byte
  logic       ph_q, ph_d;     // receive: bit sampled; ack: line already driven
  logic       oe_q, oe_d;     // pull SDA low
  logic       rw_q, rw_d;
  logic [6:0] rx_sr;
  logic [7:0] rx_byte, tx_sr;
  logic       rd_d1, framed;
  logic       err_d, ld_ah, ld_al, do_wr, do_rd, do_inc, tx_shift;

  assign pin = {i2c_sclk, i2c_sdat};

  for (genvar gi = 0; gi < 2; gi++) begin : g_filt
    i2c_slave_filt #(.FILT(FILT)) u_filt (
      .clk  (clk),
      .rstn (rstn),
      .din  (pin[gi]),
      .dout (filt[gi])
    );
  end

  // Previous filtered values for edge detection.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) filt_d <= 2'b11;
    else       filt_d <= filt;
  end

  assign scl_rise  =  filt[1] & ~filt_d[1];
  assign scl_fall  = ~filt[1] &  filt_d[1];
  assign start_det =  filt_d[0] & ~filt[0] & filt[1] & filt_d[1];
  assign stop_det  = ~filt_d[0] &  filt[0] & filt[1] & filt_d[1];

  assign rx_byte = {rx_sr, filt[0]};
  assign framed  = (state_q == S_AH) || (state_q == S_AL) ||
                   (state_q == S_WD) || (state_q == S_RD);

  // Release is combinational from reset so a mid-frame reset frees the bus at once.
  assign i2c_sdat = (oe_q && rstn) ? 1'b0 : 1'bz;

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ph_q    <= 1'b0;
      oe_q    <= 1'b0;
      rw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ph_q    <= ph_d;
      oe_q    <= oe_d;
      rw_q    <= rw_d;
    end
  end

  // Next state, SDA drive and datapath actions. START/STOP win over bit events.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ph_d     = ph_q;
    oe_d     = oe_q;
    rw_d     = rw_q;
    err_d    = 1'b0;
    ld_ah    = 1'b0;
    ld_al    = 1'b0;
    do_wr    = 1'b0;
    do_rd    = 1'b0;
    do_inc   = 1'b0;
    tx_shift = 1'b0;
    if (start_det || stop_det) begin
      // cnt counts bits completed by an SCL fall, so the rise that precedes
      // a repeated START at a byte boundary does not flag a violation.
      err_d   = framed && (cnt_q != 3'd0);
      state_d = start_det ? S_DEV : S_IDLE;
      cnt_d   = '0;
      ph_d    = 1'b0;
      oe_d    = 1'b0;
    end else begin
      case (state_q)
        S_DEV, S_AH, S_AL, S_WD: begin
          if (scl_rise) begin
            if (cnt_q == 3'd7) begin
              cnt_d = '0;
              ph_d  = 1'b0;
              case (state_q)
                S_DEV: begin
                  if (rx_byte[7:1] == DEV_ADDR) begin
                    state_d = S_DEV_ACK;
                    rw_d    = rx_byte[0];
                  end else begin
                    state_d = S_WAIT_STOP;
                  end
                end
                S_AH: begin
                  ld_ah   = 1'b1;
                  state_d = S_ACK_H;
                end
                S_AL: begin
                  ld_al   = 1'b1;
                  state_d = S_ACK_L;
                end
                default: begin
                  do_wr   = 1'b1;
                  state_d = S_ACK_W;
                end
              endcase
            end else begin
              ph_d = 1'b1;
            end
          end else if (scl_fall && ph_q) begin
            cnt_d = cnt_q + 3'd1;
            ph_d  = 1'b0;
          end
        end
        S_DEV_ACK, S_ACK_H, S_ACK_L, S_ACK_W: begin
          if (scl_fall) begin
            if (!ph_q) begin
              oe_d = 1'b1;
              ph_d = 1'b1;
            end else begin
              ph_d  = 1'b0;
              cnt_d = '0;
              oe_d  = 1'b0;
              case (state_q)
                S_DEV_ACK: begin
                  if (rw_q) begin
                    state_d = S_RD;
                    oe_d    = ~tx_sr[7];
                  end else begin
                    state_d = S_AH;
                  end
                end
                S_ACK_H: state_d = S_AL;
                default: state_d = S_WD;
              endcase
            end
          end else if (scl_rise && ph_q && (state_q == S_DEV_ACK) && rw_q) begin
            do_rd = 1'b1;
          end
        end
        S_RD: begin
          if (scl_rise) begin
            if (cnt_q == 3'd7) begin
              state_d = S_RACK;
              cnt_d   = '0;
              ph_d    = 1'b0;
            end else begin
              ph_d = 1'b1;
            end
          end else if (scl_fall && ph_q) begin
            cnt_d    = cnt_q + 3'd1;
            ph_d     = 1'b0;
            tx_shift = 1'b1;
            oe_d     = ~tx_sr[6];
          end
        end
        S_RACK: begin
          if (scl_fall) begin
            if (!ph_q) begin
              oe_d = 1'b0;
            end else begin
              state_d = S_RD;
              ph_d    = 1'b0;
              cnt_d   = '0;
              oe_d    = ~tx_sr[7];
            end
          end else if (scl_rise) begin
            do_inc = 1'b1;
            if (!filt[0]) begin
              do_rd = 1'b1;
              ph_d  = 1'b1;
            end else begin
              state_d = S_WAIT_STOP;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Shift registers, register pointer, strobes and status.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_sr    <= '0;
      tx_sr    <= '0;
      reg_addr <= '0;
      wr_data  <= '0;
      wr_en    <= 1'b0;
      rd_req   <= 1'b0;
      rd_d1    <= 1'b0;
      err      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      if (scl_rise) rx_sr <= rx_byte[6:0];
      wr_en  <= do_wr;
      rd_req <= do_rd;
      rd_d1  <= rd_req;
      err    <= err_d;
      if (do_wr) wr_data <= rx_byte;
      // rd_data is taken two clocks after the request is raised.
      if (rd_d1)         tx_sr <= rd_data;
      else if (tx_shift) tx_sr <= {tx_sr[6:0], 1'b0};
      // Write pointer advances the cycle after the strobe; read pointer on RACK.
      if (ld_ah)                 reg_addr[15:8] <= rx_byte;
      else if (ld_al)            reg_addr[7:0]  <= rx_byte;
      else if (wr_en || do_inc)  reg_addr       <= reg_addr + 16'd1;
      if (stop_det)                    busy <= 1'b0;
      else if (state_q == S_DEV_ACK)   busy <= 1'b1;
    end
  end
endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: a bit-banged I2C master with a pulled-up SDA,
// a register-file model returning reg_addr[7:0], and strobe monitors.
module tb_i2c_slave;
  localparam int Q = 10;  // quarter SCL period in clk cycles

  logic        clk = 1'b0, rstn = 1'b0, scl = 1'b1, m_low = 1'b0;
  wire         sda;
  logic        wr_en, rd_req, busy, err;
  logic [15:0] reg_addr;
  logic [7:0]  wr_data, rd_data;

  int n_chk = 0, n_fail = 0;
  int wr_cnt = 0, rd_cnt = 0, err_cnt = 0, dut_low = 0, wr_long = 0;
  logic [15:0] wa_q[$];
  logic [7:0]  wd_q[$];
  logic        wr_prev = 1'b0;

  pullup (sda);
  assign sda     = m_low ? 1'b0 : 1'bz;
  assign rd_data = reg_addr[7:0];

  i2c_slave #(.DEV_ADDR(7'h3C), .FILT(3)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .i2c_sclk (scl),
    .i2c_sdat (sda),
    .wr_en    (wr_en),
    .reg_addr (reg_addr),
    .wr_data  (wr_data),
    .rd_req   (rd_req),
    .rd_data  (rd_data),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Strobe and bus monitors, sampled away from the active edge.
  always @(negedge clk) begin
    if (rstn) begin
      if (wr_en) begin
        wr_cnt++;
        wa_q.push_back(reg_addr);
        wd_q.push_back(wr_data);
        if (wr_prev) wr_long++;
      end
      if (rd_req) rd_cnt++;
      if (err) err_cnt++;
      if (!m_low && sda === 1'b0) dut_low++;
    end
    wr_prev = wr_en;
  end

  task automatic wq(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic start_c();
    m_low = 1'b0; wq(Q); scl = 1'b1; wq(Q); m_low = 1'b1; wq(Q); scl = 1'b0; wq(Q);
  endtask

  task automatic stop_c();
    m_low = 1'b1; wq(Q); scl = 1'b1; wq(Q); m_low = 1'b0; wq(Q);
  endtask

  // Send the top n bits of b; bit index gbit gets a 2-clk SCL glitch in its low phase.
  task automatic send_bits(input logic [7:0] b, input int n, input int gbit);
    for (int i = 7; i > 7 - n; i--) begin
      m_low = ~b[i]; wq(Q);
      if (i == gbit) begin scl = 1'b1; wq(2); scl = 1'b0; wq(Q); end
      scl = 1'b1; wq(2 * Q); scl = 1'b0; wq(Q);
    end
  endtask

  task automatic get_ack(output logic ack);
    m_low = 1'b0; wq(Q); scl = 1'b1; wq(Q); ack = (sda === 1'b0); wq(Q); scl = 1'b0; wq(Q);
  endtask

  task automatic send(input string tag, input logic [7:0] b, input logic exp_ack);
    logic a;
    send_bits(b, 8, -1);
    get_ack(a);
    chk(tag, a, exp_ack);
  endtask

  task automatic read_byte(input logic do_ack, output logic [7:0] b);
    m_low = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      wq(Q); scl = 1'b1; wq(Q); b[i] = sda; wq(Q); scl = 1'b0; wq(Q);
    end
    m_low = do_ack; wq(Q); scl = 1'b1; wq(2 * Q); scl = 1'b0; wq(Q); m_low = 1'b0;
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, r0, e0;
    logic [7:0] rb;
    logic a;

    // Reset state
    wq(5);
    chk("rst wr_en", wr_en, 1'b0);
    chk("rst rd_req", rd_req, 1'b0);
    chk("rst err", err, 1'b0);
    chk("rst busy", busy, 1'b0);
    chk("rst reg_addr", reg_addr, 16'h0000);
    chk("rst wr_data", wr_data, 8'h00);
    chk("rst sda", sda, 1'b1);
    rstn = 1'b1;
    wq(10);

    // 1: single write
    w0 = wr_cnt;
    start_c();
    send("t1 ack dev", 8'h78, 1'b1);
    send("t1 ack ah", 8'h12, 1'b1);
    send("t1 ack al", 8'h34, 1'b1);
    send("t1 ack wd", 8'hAB, 1'b1);
    chk("t1 busy", busy, 1'b1);
    stop_c();
    wq(Q);
    chk("t1 wr count", wr_cnt - w0, 1);
    chk("t1 wr addr", wa_q[w0], 16'h1234);
    chk("t1 wr data", wd_q[w0], 8'hAB);
    chk("t1 reg_addr", reg_addr, 16'h1235);
    chk("t1 busy after stop", busy, 1'b0);

    // 2: burst across the pointer wrap
    w0 = wr_cnt;
    start_c();
    send("t2 ack dev", 8'h78, 1'b1);
    send("t2 ack ah", 8'hFF, 1'b1);
    send("t2 ack al", 8'hFF, 1'b1);
    send("t2 ack d0", 8'h11, 1'b1);
    send("t2 ack d1", 8'h22, 1'b1);
    stop_c();
    wq(Q);
    chk("t2 wr count", wr_cnt - w0, 2);
    chk("t2 wr0 addr", wa_q[w0], 16'hFFFF);
    chk("t2 wr0 data", wd_q[w0], 8'h11);
    chk("t2 wr1 addr", wa_q[w0 + 1], 16'h0000);
    chk("t2 wr1 data", wd_q[w0 + 1], 8'h22);
    chk("t2 reg_addr", reg_addr, 16'h0001);

    // 3: foreign device address
    w0 = wr_cnt; e0 = err_cnt; dut_low = 0;
    start_c();
    send("t3 nack dev", 8'h7A, 1'b0);
    send("t3 nack b0", 8'h00, 1'b0);
    send("t3 nack b1", 8'h55, 1'b0);
    chk("t3 busy mid", busy, 1'b0);
    send("t3 nack b2", 8'hAA, 1'b0);
    stop_c();
    wq(Q);
    chk("t3 sda never low", dut_low, 0);
    chk("t3 wr count", wr_cnt - w0, 0);
    chk("t3 busy", busy, 1'b0);
    chk("t3 err", err_cnt - e0, 0);

    // 4: address-only write, repeated START, two-byte read
    w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt;
    start_c();
    send("t4 ack dev w", 8'h78, 1'b1);
    send("t4 ack ah", 8'h00, 1'b1);
    send("t4 ack al", 8'h10, 1'b1);
    start_c();
    send("t4 ack dev r", 8'h79, 1'b1);
    read_byte(1'b1, rb);
    chk("t4 byte0", rb, 8'h10);
    read_byte(1'b0, rb);
    chk("t4 byte1", rb, 8'h11);
    wq(2);
    chk("t4 sda released", sda, 1'b1);
    stop_c();
    wq(Q);
    chk("t4 rd_req count", rd_cnt - r0, 2);
    chk("t4 reg_addr", reg_addr, 16'h0012);
    chk("t4 wr count", wr_cnt - w0, 0);
    chk("t4 err", err_cnt - e0, 0);

    // 5: STOP in the middle of a data byte
    w0 = wr_cnt; e0 = err_cnt;
    start_c();
    send("t5 ack dev", 8'h78, 1'b1);
    send("t5 ack ah", 8'h00, 1'b1);
    send("t5 ack al", 8'h20, 1'b1);
    send_bits(8'hC3, 4, -1);
    stop_c();
    wq(Q);
    chk("t5 err", err_cnt - e0, 1);
    chk("t5 wr count", wr_cnt - w0, 0);
    chk("t5 reg_addr", reg_addr, 16'h0020);
    chk("t5 busy", busy, 1'b0);

    // 6a: SCL glitch inside a data byte
    w0 = wr_cnt;
    start_c();
    send("t6 ack dev", 8'h78, 1'b1);
    send("t6 ack ah", 8'h00, 1'b1);
    send("t6 ack al", 8'h40, 1'b1);
    send_bits(8'h5A, 8, 4);
    get_ack(a);
    chk("t6 ack wd", a, 1'b1);
    stop_c();
    wq(Q);
    chk("t6 wr count", wr_cnt - w0, 1);
    chk("t6 wr addr", wa_q[w0], 16'h0040);
    chk("t6 wr data", wd_q[w0], 8'h5A);

    // 6b: reset asserted while the target holds the ACK low
    w0 = wr_cnt; e0 = err_cnt;
    start_c();
    send_bits(8'h78, 8, -1);
    m_low = 1'b0; wq(Q);
    chk("t6 ack low", sda, 1'b0);
    rstn = 1'b0;
    #1;
    chk("t6 rst sda", sda, 1'b1);
    chk("t6 rst busy", busy, 1'b0);
    chk("t6 rst reg_addr", reg_addr, 16'h0000);
    chk("t6 rst wr_data", wr_data, 8'h00);
    chk("t6 rst strobes", {wr_en, rd_req, err}, 3'b000);
    wq(5);
    scl = 1'b1;
    rstn = 1'b1;
    wq(4 * Q);
    chk("t6 exit wr", wr_cnt - w0, 0);
    chk("t6 exit err", err_cnt - e0, 0);
    chk("t6 exit busy", busy, 1'b0);
    chk("t6 exit sda", sda, 1'b1);
    chk("wr_en single cycle", wr_long, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
